sram_req_scheduler: RTL and testbench

//  Shares the single AHB-Lite port of the ECC-protected SRAM between NUM_MASTERS simple request

---
 rtl/sram_req_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_sram_req_scheduler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_scheduler.sv
// rtl/sram_req_scheduler.sv - round-robin burst scheduler onto the ECC SRAM AHB-Lite port
// Optional per-master ECC error counters: define SRAM_SCHED_ERR_CNT_EN.
module sram_req_scheduler #(
   parameter int NUM_MASTERS = 2,
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 10
) (
   input  logic                              HCLK,
   input  logic                              HRESETn,
   input  logic [NUM_MASTERS-1:0]            m_req,
   input  logic [NUM_MASTERS-1:0]            m_write,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
   input  logic [NUM_MASTERS*4-1:0]          m_len,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
   output logic [NUM_MASTERS-1:0]            m_ack,
   output logic [NUM_MASTERS-1:0]            m_rvalid,
   output logic [DATA_WIDTH-1:0]             m_rdata,
   output logic                              m_ecc_err,
   output logic [NUM_MASTERS*8-1:0]          err_cnt,
   input  logic                              err_cnt_clr,
   output logic                              s_hsel,
   output logic [1:0]                        s_htrans,
   output logic [ADDR_WIDTH-1:0]             s_haddr,
   output logic                              s_hwrite,
   output logic [2:0]                        s_hburst,
   output logic [2:0]                        s_hsize,
   output logic [DATA_WIDTH-1:0]             s_hwdata,
   output logic                              s_hready,
   input  logic [DATA_WIDTH-1:0]             s_hrdata,
   input  logic                              s_hreadyout,
   input  logic                              s_ecc_error
);
   localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam logic [1:0] HT_IDLE   = 2'b00;
   localparam logic [1:0] HT_NONSEQ = 2'b10;
   localparam logic [1:0] HT_SEQ    = 2'b11;

   typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_DRAIN} state_t;

   state_t                  state_q, state_d;
   logic [PW-1:0]           rr_ptr_q, rr_ptr_d, gnt_q, gnt_d;
   logic                    write_q, write_d, dphase_q, dphase_d, s_hsel_q, s_hsel_d;
   logic [3:0]              len_q, len_d, beat_q, beat_d;
   logic [1:0]              s_htrans_q, s_htrans_d;
   logic [2:0]              s_hburst_q, s_hburst_d;
   logic [ADDR_WIDTH-1:0]   s_haddr_q, s_haddr_d;
   logic [DATA_WIDTH-1:0]   s_hwdata_q, s_hwdata_d;

   logic                    arb_hit, rvalid_any;
   logic [PW-1:0]           arb_idx, gnt_next;
   logic [PW:0]             cand;
   logic [NUM_MASTERS-1:0]  gnt_onehot;

   // First requester at or after rr_ptr wins; the loop runs backwards so the nearest one is kept.
   always_comb begin
      arb_hit = 1'b0;
      arb_idx = '0;
      cand    = '0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         cand = {1'b0, rr_ptr_q} + (PW+1)'(i);
         if (cand >= (PW+1)'(NUM_MASTERS)) cand = cand - (PW+1)'(NUM_MASTERS);
         if (m_req[cand[PW-1:0]]) begin
            arb_hit = 1'b1;
            arb_idx = cand[PW-1:0];
         end
      end
   end

   assign gnt_next   = (gnt_q == PW'(NUM_MASTERS - 1)) ? '0 : gnt_q + PW'(1);
   assign gnt_onehot = NUM_MASTERS'(1) << gnt_q;
   assign rvalid_any = dphase_q & ~write_q & s_hreadyout;

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      gnt_d      = gnt_q;
      write_d    = write_q;
      len_d      = len_q;
      beat_d     = beat_q;
      dphase_d   = dphase_q;
      s_hsel_d   = s_hsel_q;
      s_htrans_d = s_htrans_q;
      s_hburst_d = s_hburst_q;
      s_haddr_d  = s_haddr_q;
      s_hwdata_d = s_hwdata_q;
      // Nothing on the bus may move while the SRAM stalls.
      if (s_hreadyout) begin
         dphase_d = (state_q == ST_BURST);
         if (state_q == ST_BURST && write_q) s_hwdata_d = m_wdata[gnt_q*DATA_WIDTH +: DATA_WIDTH];
         if (state_q == ST_BURST) begin
            if (beat_q == len_q) begin
               state_d    = ST_DRAIN;
               s_htrans_d = HT_IDLE;
               s_hsel_d   = 1'b0;
               rr_ptr_d   = gnt_next;
            end else begin
               beat_d     = beat_q + 4'd1;
               s_haddr_d  = s_haddr_q + ADDR_WIDTH'(1);
               s_htrans_d = HT_SEQ;
            end
         end else if (arb_hit) begin
            state_d    = ST_BURST;
            gnt_d      = arb_idx;
            write_d    = m_write[arb_idx];
            len_d      = m_len[arb_idx*4 +: 4];
            beat_d     = 4'd0;
            s_haddr_d  = m_addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
            s_htrans_d = HT_NONSEQ;
            s_hburst_d = (m_len[arb_idx*4 +: 4] == 4'd0) ? 3'b000 : 3'b001;
            s_hsel_d   = 1'b1;
         end else begin
            state_d    = ST_IDLE;
            s_htrans_d = HT_IDLE;
            s_hsel_d   = 1'b0;
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         gnt_q      <= '0;
         write_q    <= 1'b0;
         len_q      <= '0;
         beat_q     <= '0;
         dphase_q   <= 1'b0;
         s_hsel_q   <= 1'b0;
         s_htrans_q <= HT_IDLE;
         s_hburst_q <= 3'b000;
         s_haddr_q  <= '0;
         s_hwdata_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         gnt_q      <= gnt_d;
         write_q    <= write_d;
         len_q      <= len_d;
         beat_q     <= beat_d;
         dphase_q   <= dphase_d;
         s_hsel_q   <= s_hsel_d;
         s_htrans_q <= s_htrans_d;
         s_hburst_q <= s_hburst_d;
         s_haddr_q  <= s_haddr_d;
         s_hwdata_q <= s_hwdata_d;
      end
   end

   assign m_ack     = (state_q == ST_BURST && s_hreadyout) ? gnt_onehot : '0;
   assign m_rvalid  = rvalid_any ? gnt_onehot : '0;
   assign m_rdata   = rvalid_any ? s_hrdata : '0;
   assign m_ecc_err = rvalid_any & s_ecc_error;
   assign s_hsel    = s_hsel_q;
   assign s_htrans  = s_htrans_q;
   assign s_haddr   = s_haddr_q;
   assign s_hwrite  = write_q;
   assign s_hburst  = s_hburst_q;
   assign s_hsize   = 3'b010;
   assign s_hwdata  = s_hwdata_q;
   assign s_hready  = s_hreadyout;

`ifdef SRAM_SCHED_ERR_CNT_EN
   logic [NUM_MASTERS*8-1:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_cnt_clr) err_cnt_d = '0;
      else if (m_ecc_err && err_cnt_q[gnt_q*8 +: 8] != 8'hFF)
         err_cnt_d[gnt_q*8 +: 8] = err_cnt_q[gnt_q*8 +: 8] + 8'd1;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) err_cnt_q <= '0;
      else          err_cnt_q <= err_cnt_d;
   end

   assign err_cnt = err_cnt_q;
`else
   logic unused_err_cnt_clr;
   assign unused_err_cnt_clr = err_cnt_clr;
   assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_sram_req_scheduler.sv
// tb/tb_sram_req_scheduler.sv - directed bench for sram_req_scheduler with a behavioural SRAM slave
module tb_sram_req_scheduler;
   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic [1:0]  m_req, m_write, m_ack, m_rvalid;
   logic [19:0] m_addr;
   logic [7:0]  m_len;
   logic [63:0] m_wdata;
   logic [31:0] m_rdata;
   logic        m_ecc_err;
   logic [15:0] err_cnt;
   logic        err_cnt_clr;
   logic        s_hsel, s_hwrite, s_hready, s_hreadyout, s_ecc_error;
   logic [1:0]  s_htrans;
   logic [9:0]  s_haddr;
   logic [2:0]  s_hburst, s_hsize;
   logic [31:0] s_hwdata, s_hrdata;

   int n_cmp = 0;
   int n_err = 0;

   sram_req_scheduler dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .m_req(m_req), .m_write(m_write), .m_addr(m_addr),
      .m_len(m_len), .m_wdata(m_wdata), .m_ack(m_ack), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
      .m_ecc_err(m_ecc_err), .err_cnt(err_cnt), .err_cnt_clr(err_cnt_clr), .s_hsel(s_hsel),
      .s_htrans(s_htrans), .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hburst(s_hburst),
      .s_hsize(s_hsize), .s_hwdata(s_hwdata), .s_hready(s_hready), .s_hrdata(s_hrdata),
      .s_hreadyout(s_hreadyout), .s_ecc_error(s_ecc_error)
   );

   always #5 HCLK = ~HCLK;

   // SRAM slave: preloaded with A500_0000|addr on reset
   logic [31:0] mem [1024];
   logic        dp_act, dp_wr;
   logic [9:0]  dp_addr;
   always @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dp_act <= 1'b0; dp_wr <= 1'b0; dp_addr <= '0;
         for (int i = 0; i < 1024; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      end else if (s_hready) begin
         if (dp_act && dp_wr) mem[dp_addr] <= s_hwdata;
         dp_act  <= s_hsel && s_htrans[1];
         dp_wr   <= s_hwrite;
         dp_addr <= s_haddr;
      end
   end
   assign s_hrdata = (dp_act && !dp_wr) ? mem[dp_addr] : 32'h0;

   logic [31:0] wtbl [16];
   logic [1:0]  r_htrans [16];
   logic [9:0]  r_haddr [16];
   logic [2:0]  r_hburst [16];
   int          r_ackc [16];
   logic [31:0] r_rdata [16];
   logic        r_ecc [16];
   int          r_rvc [16];
   int          n_rd, n_ecc;
   logic [9:0]  c_haddr [64];
   logic [31:0] c_hwdata [64];
   int          stall_from = 0, stall_n = 0;
   int          a_ord [4], a_cyc [4];
   logic [31:0] a_rd [4];

   task automatic idle(input int n);
      repeat (n) @(negedge HCLK);
   endtask

   task automatic do_burst(input int g, input logic wr, input logic [9:0] addr, input logic [3:0] len);
      int beat = 0, cyc = 0;
      logic prev_ack = 1'b0;
      bit done = 1'b0;
      n_rd = 0; n_ecc = 0;
      m_write[g] = wr; m_addr[g*10 +: 10] = addr; m_len[g*4 +: 4] = len;
      m_wdata[g*32 +: 32] = wtbl[0]; m_req[g] = 1'b1;
      while (!done && cyc < 200) begin
         @(negedge HCLK);
         cyc++;
         s_hreadyout = !(cyc >= stall_from && cyc < stall_from + stall_n);
         #1;
         if (cyc < 64) begin c_haddr[cyc] = s_haddr; c_hwdata[cyc] = s_hwdata; end
         if (m_rvalid[g]) begin
            if (n_rd < 16) begin r_rdata[n_rd] = m_rdata; r_ecc[n_rd] = m_ecc_err; r_rvc[n_rd] = cyc; end
            if (m_ecc_err) n_ecc++;
            n_rd++;
         end
         if (prev_ack) begin
            if (beat > int'(len)) m_req[g] = 1'b0;
            else m_wdata[g*32 +: 32] = wtbl[beat];
         end
         prev_ack = m_ack[g];
         if (prev_ack) begin
            if (beat < 16) begin
               r_htrans[beat] = s_htrans; r_haddr[beat] = s_haddr;
               r_hburst[beat] = s_hburst; r_ackc[beat] = cyc;
            end
            beat++;
         end
         done = (beat > int'(len)) && !prev_ack && (wr || n_rd > int'(len));
      end
      m_req[g] = 1'b0;
      s_hreadyout = 1'b1;
      n_cmp++;
      if (!done) begin n_err++; $display("FAIL burst_timeout m%0d got beats=%0d exp=%0d", g, beat, int'(len) + 1); end
   endtask

   // Both masters issue single reads (M0 from 0x100, M1 from 0x200); nbX = bursts each wants.
   task automatic run_pair(input int nb0, input int nb1);
      int rem [2];
      int cyc = 0, n_ev = 0, n_rv = 0;
      rem[0] = nb0; rem[1] = nb1;
      m_write = 2'b00; m_len = 8'h00; m_addr = {10'h200, 10'h100};
      m_req = {nb1 > 0, nb0 > 0};
      while (n_rv < nb0 + nb1 && cyc < 50) begin
         @(negedge HCLK);
         cyc++;
         #1;
         if (|m_rvalid && n_rv < 4) begin a_rd[n_rv] = m_rdata; n_rv++; end
         for (int g = 0; g < 2; g++) begin
            if (m_ack[g] && n_ev < 4) begin
               a_ord[n_ev] = g; a_cyc[n_ev] = cyc; n_ev++;
               rem[g]--;
               if (rem[g] == 0) m_req[g] = 1'b0;
            end
         end
      end
      m_req = 2'b00;
      n_cmp++;
      if (n_rv != nb0 + nb1) begin n_err++; $display("FAIL pair_timeout got=%0d exp=%0d", n_rv, nb0 + nb1); end
   endtask

   task automatic test_reset;
      HRESETn = 1'b0; m_req = '0; m_write = '0; m_addr = '0; m_len = '0; m_wdata = '0;
      err_cnt_clr = 1'b0; s_hreadyout = 1'b1; s_ecc_error = 1'b0;
      idle(3);
      #1;
      n_cmp++; if (s_htrans !== 2'b00) begin n_err++; $display("FAIL rst_htrans got=%b exp=00", s_htrans); end
      n_cmp++; if (s_hsel !== 1'b0) begin n_err++; $display("FAIL rst_hsel got=%b exp=0", s_hsel); end
      n_cmp++; if (m_ack !== 2'b00 || m_rvalid !== 2'b00) begin n_err++; $display("FAIL rst_ack_rvalid got=%b/%b exp=00/00", m_ack, m_rvalid); end
      n_cmp++; if (s_haddr !== 10'h0 || s_hwdata !== 32'h0) begin n_err++; $display("FAIL rst_addr_wdata got=%h/%h exp=0/0", s_haddr, s_hwdata); end
      n_cmp++; if (m_rdata !== 32'h0 || m_ecc_err !== 1'b0) begin n_err++; $display("FAIL rst_rdata_ecc got=%h/%b exp=0/0", m_rdata, m_ecc_err); end
      n_cmp++; if (err_cnt !== 16'h0) begin n_err++; $display("FAIL rst_err_cnt got=%h exp=0", err_cnt); end
      @(negedge HCLK); HRESETn = 1'b1;
      idle(2);
      n_cmp++; if (s_htrans !== 2'b00 || s_hsel !== 1'b0) begin n_err++; $display("FAIL idle_no_req got=%b/%b exp=00/0", s_htrans, s_hsel); end
   endtask

   task automatic test_arbitration;
      run_pair(2, 1);
      for (int i = 0; i < 3; i++) begin
         int eo = (i == 1) ? 1 : 0;
         n_cmp++; if (a_ord[i] != eo) begin n_err++; $display("FAIL arb_order%0d got=m%0d exp=m%0d", i, a_ord[i], eo); end
         n_cmp++; if (a_cyc[i] != 2*i + 1) begin n_err++; $display("FAIL arb_cycle%0d got=%0d exp=%0d", i, a_cyc[i], 2*i + 1); end
         n_cmp++; if (a_rd[i] !== (eo == 1 ? 32'hA500_0200 : 32'hA500_0100)) begin n_err++; $display("FAIL arb_rdata%0d got=%h", i, a_rd[i]); end
      end
      idle(2);
   endtask

   task automatic test_write_wrap;
      logic [9:0]  ea [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
      logic [1:0]  et [4] = '{2'b10, 2'b11, 2'b11, 2'b11};
      wtbl[0] = 32'hAAAA_AAAA; wtbl[1] = 32'hBBBB_BBBB; wtbl[2] = 32'hCCCC_CCCC; wtbl[3] = 32'hDDDD_DDDD;
      do_burst(0, 1'b1, 10'h3FE, 4'd3);
      idle(2);
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (r_haddr[i] !== ea[i]) begin n_err++; $display("FAIL wr_haddr%0d got=%h exp=%h", i, r_haddr[i], ea[i]); end
         n_cmp++; if (r_htrans[i] !== et[i]) begin n_err++; $display("FAIL wr_htrans%0d got=%b exp=%b", i, r_htrans[i], et[i]); end
         n_cmp++; if (r_hburst[i] !== 3'b001) begin n_err++; $display("FAIL wr_hburst%0d got=%b exp=001", i, r_hburst[i]); end
         n_cmp++; if (r_ackc[i] != i + 1) begin n_err++; $display("FAIL wr_ackcyc%0d got=%0d exp=%0d", i, r_ackc[i], i + 1); end
         n_cmp++; if (c_hwdata[i+2] !== wtbl[i]) begin n_err++; $display("FAIL wr_hwdata%0d got=%h exp=%h", i, c_hwdata[i+2], wtbl[i]); end
         n_cmp++; if (mem[ea[i]] !== wtbl[i]) begin n_err++; $display("FAIL wr_mem%0d got=%h exp=%h", i, mem[ea[i]], wtbl[i]); end
      end
      n_cmp++; if (s_hsize !== 3'b010) begin n_err++; $display("FAIL hsize got=%b exp=010", s_hsize); end
   endtask

   task automatic test_read_latency;
      wtbl[0] = 32'h1234_5678;
      do_burst(0, 1'b1, 10'h010, 4'd0);
      idle(1);
      do_burst(0, 1'b0, 10'h010, 4'd0);
      n_cmp++; if (n_rd != 1) begin n_err++; $display("FAIL rd_count got=%0d exp=1", n_rd); end
      n_cmp++; if (r_rvc[0] != 2) begin n_err++; $display("FAIL rd_latency got=%0d exp=2", r_rvc[0]); end
      n_cmp++; if (r_rdata[0] !== 32'h1234_5678) begin n_err++; $display("FAIL rd_data got=%h exp=12345678", r_rdata[0]); end
      n_cmp++; if (r_ecc[0] !== 1'b0) begin n_err++; $display("FAIL rd_ecc got=%b exp=0", r_ecc[0]); end
      n_cmp++; if (r_hburst[0] !== 3'b000 || r_htrans[0] !== 2'b10) begin n_err++; $display("FAIL rd_single got=%b/%b exp=000/10", r_hburst[0], r_htrans[0]); end
      idle(2);
   endtask

   task automatic test_stall;
      int ec [3] = '{1, 4, 5};
      wtbl[0] = 32'h0D00_0000; wtbl[1] = 32'h0D00_0001; wtbl[2] = 32'h0D00_0002;
      stall_from = 2; stall_n = 2;
      do_burst(0, 1'b1, 10'h020, 4'd2);
      stall_n = 0;
      idle(2);
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (r_ackc[i] != ec[i]) begin n_err++; $display("FAIL st_ackcyc%0d got=%0d exp=%0d", i, r_ackc[i], ec[i]); end
         n_cmp++; if (r_haddr[i] !== 10'h020 + 10'(i)) begin n_err++; $display("FAIL st_haddr%0d got=%h", i, r_haddr[i]); end
         n_cmp++; if (mem[10'h020 + 10'(i)] !== wtbl[i]) begin n_err++; $display("FAIL st_mem%0d got=%h exp=%h", i, mem[10'h020 + 10'(i)], wtbl[i]); end
      end
      for (int c = 2; c <= 3; c++) begin
         n_cmp++; if (c_haddr[c] !== 10'h021) begin n_err++; $display("FAIL st_hold_addr c%0d got=%h exp=021", c, c_haddr[c]); end
      end
      for (int c = 2; c <= 4; c++) begin
         n_cmp++; if (c_hwdata[c] !== 32'h0D00_0000) begin n_err++; $display("FAIL st_hold_wdata c%0d got=%h exp=0d000000", c, c_hwdata[c]); end
      end
      n_cmp++; if (c_hwdata[5] !== 32'h0D00_0001) begin n_err++; $display("FAIL st_wdata_next got=%h exp=0d000001", c_hwdata[5]); end
   endtask

   task automatic test_err_cnt;
`ifdef SRAM_SCHED_ERR_CNT_EN
      logic [7:0] e1 = 8'd15, e_sat = 8'd255;
`else
      logic [7:0] e1 = 8'd0, e_sat = 8'd0;
`endif
      s_ecc_error = 1'b1;
      do_burst(1, 1'b0, 10'h080, 4'd14);
      idle(2);
      n_cmp++; if (n_ecc != 15) begin n_err++; $display("FAIL ecc_flag got=%0d exp=15", n_ecc); end
      n_cmp++; if (err_cnt[15:8] !== e1) begin n_err++; $display("FAIL errcnt_15 got=%0d exp=%0d", err_cnt[15:8], e1); end
      for (int b = 0; b < 19; b++) do_burst(1, 1'b0, 10'h080, 4'd14);
      idle(2);
      s_ecc_error = 1'b0;
      n_cmp++; if (err_cnt[15:8] !== e_sat) begin n_err++; $display("FAIL errcnt_sat got=%0d exp=%0d", err_cnt[15:8], e_sat); end
      n_cmp++; if (err_cnt[7:0] !== 8'd0) begin n_err++; $display("FAIL errcnt_m0 got=%0d exp=0", err_cnt[7:0]); end
      err_cnt_clr = 1'b1;
      @(negedge HCLK);
      err_cnt_clr = 1'b0;
      #1;
      n_cmp++; if (err_cnt !== 16'h0) begin n_err++; $display("FAIL errcnt_clr got=%h exp=0", err_cnt); end
      idle(1);
   endtask

   task automatic test_reset_mid_burst;
      do_burst(0, 1'b0, 10'h040, 4'd0);
      idle(1);
      m_write[1] = 1'b1; m_addr[19:10] = 10'h300; m_len[7:4] = 4'd7; m_wdata[63:32] = 32'h5555_0000;
      m_req[1] = 1'b1;
      idle(3);
      #1;
      n_cmp++; if (m_ack[1] !== 1'b1) begin n_err++; $display("FAIL mid_active got=%b exp=1", m_ack[1]); end
      HRESETn = 1'b0;
      #1;
      n_cmp++; if (s_htrans !== 2'b00 || s_hsel !== 1'b0) begin n_err++; $display("FAIL mid_rst_bus got=%b/%b exp=00/0", s_htrans, s_hsel); end
      n_cmp++; if (m_ack !== 2'b00) begin n_err++; $display("FAIL mid_rst_ack got=%b exp=00", m_ack); end
      m_req = 2'b00;
      @(negedge HCLK); HRESETn = 1'b1;
      idle(1);
      run_pair(1, 1);
      n_cmp++; if (a_ord[0] != 0 || a_ord[1] != 1) begin n_err++; $display("FAIL mid_rr_ptr got=m%0d,m%0d exp=m0,m1", a_ord[0], a_ord[1]); end
      idle(2);
   endtask

   initial begin
      test_reset();
      test_arbitration();
      test_write_wrap();
      test_read_latency();
      test_stall();
      test_err_cnt();
      test_reset_mid_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
